// File: rtl/dwconv_pkg.sv
// Shared definitions for the depthwise conv engine: default widths,
// FSM encoding and the signed MAC product width.
package dwconv_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 32;
   localparam int DEF_DIM_W  = 8;
   localparam int DEF_ADDR_W = 16;

   // (x + offset) spans DATA_W+2 bits when both operands sit at their
   // extremes, so the product keeps one guard bit above DATA_W+1+DATA_W.
   function automatic int prod_width(input int data_w);
      return data_w + 1 + data_w + 1;
   endfunction

   localparam int DEF_PROD_W = prod_width(DEF_DATA_W);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BIAS  = 3'd1,
      ST_TAP   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/dwconv2d_engine_if.sv
// Memory read ports (input, filter, bias) and result write port of the
// depthwise conv engine. master = engine side, slave = memory/sink side.
interface dwconv2d_engine_if
   import dwconv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              in_rd_en;
   logic [ADDR_W-1:0] in_rd_addr;
   logic [DATA_W-1:0] in_rd_data;

   logic              flt_rd_en;
   logic [ADDR_W-1:0] flt_rd_addr;
   logic [DATA_W-1:0] flt_rd_data;

   logic              bias_rd_en;
   logic [ADDR_W-1:0] bias_rd_addr;
   logic [ACC_W-1:0]  bias_rd_data;

   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [ACC_W-1:0]  out_data;
   logic              out_ready;

   modport master (
      output in_rd_en, in_rd_addr, input in_rd_data,
      output flt_rd_en, flt_rd_addr, input flt_rd_data,
      output bias_rd_en, bias_rd_addr, input bias_rd_data,
      output out_valid, out_addr, out_data, input out_ready
   );

   modport slave (
      input in_rd_en, in_rd_addr, output in_rd_data,
      input flt_rd_en, flt_rd_addr, output flt_rd_data,
      input bias_rd_en, bias_rd_addr, output bias_rd_data,
      input out_valid, out_addr, out_data, output out_ready
   );
endinterface

// File: rtl/dwconv_addr_gen.sv
// Combinational tap address generator: input coordinate from the output
// position and kernel offset, zero-padding bounds check, and NHWC
// input/filter element addresses.
module dwconv_addr_gen
   import dwconv_pkg::*;
#(
   parameter int DIM_W  = DEF_DIM_W,
   parameter int ADDR_W = DEF_ADDR_W
)(
   input  logic [DIM_W-1:0]  oy_i,
   input  logic [DIM_W-1:0]  ox_i,
   input  logic [DIM_W-1:0]  ch_i,
   input  logic [DIM_W-1:0]  ky_i,
   input  logic [DIM_W-1:0]  kx_i,
   input  logic [DIM_W-1:0]  cfg_h_i,
   input  logic [DIM_W-1:0]  cfg_w_i,
   input  logic [DIM_W-1:0]  cfg_c_i,
   input  logic [DIM_W-1:0]  cfg_kw_i,
   input  logic [DIM_W-1:0]  cfg_stride_i,
   input  logic [DIM_W-1:0]  cfg_pad_top_i,
   input  logic [DIM_W-1:0]  cfg_pad_left_i,
   input  logic [ADDR_W-1:0] in_base_i,
   input  logic [ADDR_W-1:0] flt_base_i,
   output logic              in_bounds_o,
   output logic [ADDR_W-1:0] in_addr_o,
   output logic [ADDR_W-1:0] flt_addr_o
);
   // Coordinates need room for oy*stride plus a sign bit.
   localparam int CW = 2 * DIM_W + 2;
   localparam int LW = 3 * DIM_W + 2;

   logic signed [CW-1:0] ih_s;
   logic signed [CW-1:0] iw_s;
   logic [LW-1:0]        in_lin_s;
   logic [LW-1:0]        flt_lin_s;

   // Signed input coordinate, padding bounds check and linear addresses
   always_comb begin
      ih_s = $signed(CW'(oy_i) * CW'(cfg_stride_i)) - $signed(CW'(cfg_pad_top_i))
           + $signed(CW'(ky_i));
      iw_s = $signed(CW'(ox_i) * CW'(cfg_stride_i)) - $signed(CW'(cfg_pad_left_i))
           + $signed(CW'(kx_i));
      in_bounds_o = !ih_s[CW-1] && !iw_s[CW-1] &&
                    (ih_s < $signed(CW'(cfg_h_i))) && (iw_s < $signed(CW'(cfg_w_i)));
      // Inside the bounds ih/iw fit in DIM_W bits, so the low slice is exact.
      in_lin_s  = (LW'(ih_s[DIM_W-1:0]) * LW'(cfg_w_i) + LW'(iw_s[DIM_W-1:0]))
                * LW'(cfg_c_i) + LW'(ch_i);
      flt_lin_s = (LW'(ky_i) * LW'(cfg_kw_i) + LW'(kx_i)) * LW'(cfg_c_i) + LW'(ch_i);
      in_addr_o  = in_base_i + ADDR_W'(in_lin_s);
      flt_addr_o = flt_base_i + ADDR_W'(flt_lin_s);
   end
endmodule

// File: rtl/dwconv2d_engine.sv
// Depthwise 2-D convolution engine (int8, NHWC, depth multiplier 1).
// One tap per cycle; read data is consumed one cycle after issue, so the
// MAC runs one stage behind the tap counters and DRAIN absorbs the last tap.
module dwconv2d_engine
   import dwconv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int DIM_W  = DEF_DIM_W,
   parameter int ADDR_W = DEF_ADDR_W
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        in_base,
   input  logic [ADDR_W-1:0]        flt_base,
   input  logic [ADDR_W-1:0]        bias_base,
   input  logic [ADDR_W-1:0]        out_base,
   input  logic [DIM_W-1:0]         cfg_h,
   input  logic [DIM_W-1:0]         cfg_w,
   input  logic [DIM_W-1:0]         cfg_c,
   input  logic [DIM_W-1:0]         cfg_kh,
   input  logic [DIM_W-1:0]         cfg_kw,
   input  logic [DIM_W-1:0]         cfg_oh,
   input  logic [DIM_W-1:0]         cfg_ow,
   input  logic [DIM_W-1:0]         cfg_stride,
   input  logic [DIM_W-1:0]         cfg_pad_top,
   input  logic [DIM_W-1:0]         cfg_pad_left,
   input  logic signed [DATA_W:0]   in_offset,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   dwconv2d_engine_if.master        bus
);
   localparam int PROD_W = prod_width(DATA_W);
   localparam int SUM_W  = DATA_W + 2;

   state_e state_q, state_d;

   logic [DIM_W-1:0]  h_q, w_q, c_q, kh_q, kw_q, oh_q, ow_q;
   logic [DIM_W-1:0]  stride_q, pad_top_q, pad_left_q;
   logic [ADDR_W-1:0] in_base_q, flt_base_q, bias_base_q, out_base_q;
   logic signed [DATA_W:0] offset_q;
   logic              err_q;

   logic [DIM_W-1:0]  oy_q, ox_q, ch_q, ky_q, kx_q;
   logic [ADDR_W-1:0] out_idx_q;

   logic              bias_ph_q, tap_ph_q;
   logic [ACC_W-1:0]  acc_q, acc_d;

   logic              out_valid_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [ACC_W-1:0]  out_data_q;

   logic              cfg_bad_s, last_tap_s, last_out_s, in_bounds_s;
   logic [ADDR_W-1:0] in_addr_s, flt_addr_s;
   logic signed [SUM_W-1:0]  xo_s;
   logic signed [PROD_W-1:0] prod_s;

   dwconv_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_addr_gen (
      .oy_i(oy_q), .ox_i(ox_q), .ch_i(ch_q), .ky_i(ky_q), .kx_i(kx_q),
      .cfg_h_i(h_q), .cfg_w_i(w_q), .cfg_c_i(c_q), .cfg_kw_i(kw_q),
      .cfg_stride_i(stride_q), .cfg_pad_top_i(pad_top_q), .cfg_pad_left_i(pad_left_q),
      .in_base_i(in_base_q), .flt_base_i(flt_base_q),
      .in_bounds_o(in_bounds_s), .in_addr_o(in_addr_s), .flt_addr_o(flt_addr_s)
   );

   // Loop-end and configuration-error decodes
   always_comb begin
      cfg_bad_s  = (cfg_c == DIM_W'(0)) || (cfg_kh == DIM_W'(0)) || (cfg_kw == DIM_W'(0)) ||
                   (cfg_oh == DIM_W'(0)) || (cfg_ow == DIM_W'(0)) || (cfg_stride == DIM_W'(0));
      last_tap_s = (ky_q == kh_q - DIM_W'(1)) && (kx_q == kw_q - DIM_W'(1));
      last_out_s = (ch_q == c_q - DIM_W'(1)) && (ox_q == ow_q - DIM_W'(1)) &&
                   (oy_q == oh_q - DIM_W'(1));
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = cfg_bad_s ? ST_DONE : ST_BIAS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BIAS:  state_d = ST_TAP;
         ST_TAP: begin
            if (last_tap_s) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_TAP;
            end
         end
         ST_DRAIN: state_d = ST_WRITE;
         ST_WRITE: begin
            if (bus.out_ready) begin
               state_d = last_out_s ? ST_DONE : ST_BIAS;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: status flags, read-port strobes and gated addresses
   always_comb begin
      busy             = (state_q != ST_IDLE);
      done             = (state_q == ST_DONE);
      err              = (state_q == ST_DONE) && err_q;
      bus.bias_rd_en   = (state_q == ST_BIAS);
      bus.in_rd_en     = (state_q == ST_TAP) && in_bounds_s;
      bus.flt_rd_en    = (state_q == ST_TAP) && in_bounds_s;
      bus.bias_rd_addr = bus.bias_rd_en ? (bias_base_q + ADDR_W'(ch_q)) : ADDR_W'(0);
      bus.in_rd_addr   = bus.in_rd_en ? in_addr_s : ADDR_W'(0);
      bus.flt_rd_addr  = bus.flt_rd_en ? flt_addr_s : ADDR_W'(0);
      bus.out_valid    = out_valid_q;
      bus.out_addr     = out_addr_q;
      bus.out_data     = out_data_q;
   end

   // Latch the geometry and bases when a start is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         {h_q, w_q, c_q, kh_q, kw_q, oh_q, ow_q} <= '0;
         {stride_q, pad_top_q, pad_left_q}       <= '0;
         {in_base_q, flt_base_q, bias_base_q, out_base_q} <= '0;
         offset_q <= '0;
         err_q    <= 1'b0;
      end else if ((state_q == ST_IDLE) && start) begin
         h_q <= cfg_h;   w_q <= cfg_w;   c_q <= cfg_c;
         kh_q <= cfg_kh; kw_q <= cfg_kw; oh_q <= cfg_oh; ow_q <= cfg_ow;
         stride_q <= cfg_stride; pad_top_q <= cfg_pad_top; pad_left_q <= cfg_pad_left;
         in_base_q <= in_base; flt_base_q <= flt_base;
         bias_base_q <= bias_base; out_base_q <= out_base;
         offset_q <= in_offset;
         err_q    <= cfg_bad_s;
      end
   end

   // Loop counters: taps ky/kx inside an output, then c, ox, oy between outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         {oy_q, ox_q, ch_q, ky_q, kx_q} <= '0;
         out_idx_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  {oy_q, ox_q, ch_q, ky_q, kx_q} <= '0;
                  out_idx_q <= '0;
               end
            end
            ST_TAP: begin
               if (last_tap_s) begin
                  ky_q <= DIM_W'(0);
                  kx_q <= DIM_W'(0);
               end else if (kx_q == kw_q - DIM_W'(1)) begin
                  kx_q <= DIM_W'(0);
                  ky_q <= ky_q + DIM_W'(1);
               end else begin
                  kx_q <= kx_q + DIM_W'(1);
               end
            end
            ST_WRITE: begin
               if (bus.out_ready) begin
                  out_idx_q <= out_idx_q + ADDR_W'(1);
                  if (ch_q == c_q - DIM_W'(1)) begin
                     ch_q <= DIM_W'(0);
                     if (ox_q == ow_q - DIM_W'(1)) begin
                        ox_q <= DIM_W'(0);
                        oy_q <= oy_q + DIM_W'(1);
                     end else begin
                        ox_q <= ox_q + DIM_W'(1);
                     end
                  end else begin
                     ch_q <= ch_q + DIM_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // MAC data phase: bias load or (x + offset) * w accumulate, one cycle after issue
   always_comb begin
      xo_s   = $signed({{2{bus.in_rd_data[DATA_W-1]}}, bus.in_rd_data})
             + $signed({offset_q[DATA_W], offset_q});
      prod_s = $signed({{DATA_W{xo_s[SUM_W-1]}}, xo_s})
             * $signed({{SUM_W{bus.flt_rd_data[DATA_W-1]}}, bus.flt_rd_data});
      if (bias_ph_q) begin
         acc_d = bus.bias_rd_data;
      end else if (tap_ph_q) begin
         acc_d = acc_q + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator and read-phase tracking registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         bias_ph_q <= 1'b0;
         tap_ph_q  <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         bias_ph_q <= (state_q == ST_BIAS);
         tap_ph_q  <= (state_q == ST_TAP) && in_bounds_s;
      end
   end

   // Result register: captured on DRAIN, held until the sink accepts it
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else if (state_q == ST_DRAIN) begin
         out_valid_q <= 1'b1;
         out_addr_q  <= out_base_q + out_idx_q;
         out_data_q  <= acc_d;
      end else if ((state_q == ST_WRITE) && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dwconv2d_engine.sv
// Scoreboard bench for dwconv2d_engine: directed geometries with
// hand-computed results; a negedge monitor pops expectations on each write.
module tb_dwconv2d_engine;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 32;
   localparam int DIM_W  = 8;
   localparam int ADDR_W = 16;

   localparam logic [ADDR_W-1:0] IN_B   = 16'h0100;
   localparam logic [ADDR_W-1:0] FLT_B  = 16'h0200;
   localparam logic [ADDR_W-1:0] BIAS_B = 16'h0300;
   localparam logic [ADDR_W-1:0] OUT_B  = 16'h0400;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [ACC_W-1:0]  data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [ADDR_W-1:0] in_base = IN_B, flt_base = FLT_B, bias_base = BIAS_B, out_base = OUT_B;
   logic [DIM_W-1:0] cfg_h, cfg_w, cfg_c, cfg_kh, cfg_kw, cfg_oh, cfg_ow;
   logic [DIM_W-1:0] cfg_stride, cfg_pad_top, cfg_pad_left;
   logic signed [DATA_W:0] in_offset = '0;
   logic busy, done, err;

   dwconv2d_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

   dwconv2d_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_base(in_base), .flt_base(flt_base), .bias_base(bias_base), .out_base(out_base),
      .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_c(cfg_c), .cfg_kh(cfg_kh), .cfg_kw(cfg_kw),
      .cfg_oh(cfg_oh), .cfg_ow(cfg_ow), .cfg_stride(cfg_stride),
      .cfg_pad_top(cfg_pad_top), .cfg_pad_left(cfg_pad_left), .in_offset(in_offset),
      .busy(busy), .done(done), .err(err), .bus(bus)
   );

   logic [DATA_W-1:0] in_mem   [0:65535];
   logic [DATA_W-1:0] flt_mem  [0:65535];
   logic [ACC_W-1:0]  bias_mem [0:65535];

   exp_t exp_q[$];
   int total = 0, bad = 0;
   int cyc = 0;
   int in_rd_cnt = 0, flt_rd_cnt = 0, bias_rd_cnt = 0;
   int hs_cnt = 0, last_hs_cyc = -1;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Latency-1 memory models with read counters
   always @(posedge clk) begin
      if (bus.in_rd_en) begin
         bus.in_rd_data <= in_mem[bus.in_rd_addr];
         in_rd_cnt <= in_rd_cnt + 1;
      end
      if (bus.flt_rd_en) begin
         bus.flt_rd_data <= flt_mem[bus.flt_rd_addr];
         flt_rd_cnt <= flt_rd_cnt + 1;
      end
      if (bus.bias_rd_en) begin
         bus.bias_rd_data <= bias_mem[bus.bias_rd_addr];
         bias_rd_cnt <= bias_rd_cnt + 1;
      end
   end

   // Scoreboard monitor: every accepted write pops one expectation
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got addr=%h data=%0d want none", bus.out_addr,
                     $signed(bus.out_data));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.out_addr !== e.addr || bus.out_data !== e.data) begin
               bad++;
               $display("FAIL write got addr=%h data=%0d want addr=%h data=%0d",
                        bus.out_addr, $signed(bus.out_data), e.addr, $signed(e.data));
            end
         end
         hs_cnt++;
         last_hs_cyc = cyc;
      end
   end

   task automatic check(input string name, input longint act, input longint want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end
   endtask

   task automatic set_cfg(input int h, input int w, input int c, input int k,
                          input int oh, input int ow, input int s, input int p);
      cfg_h = DIM_W'(h); cfg_w = DIM_W'(w); cfg_c = DIM_W'(c);
      cfg_kh = DIM_W'(k); cfg_kw = DIM_W'(k); cfg_oh = DIM_W'(oh); cfg_ow = DIM_W'(ow);
      cfg_stride = DIM_W'(s); cfg_pad_top = DIM_W'(p); cfg_pad_left = DIM_W'(p);
   endtask

   task automatic push(input int idx, input int data);
      exp_t e;
      e.addr = OUT_B + ADDR_W'(idx);
      e.data = ACC_W'(data);
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            dcyc = cyc;
            break;
         end
      end
      total++;
      if (dcyc < 0) begin
         bad++;
         $display("FAIL done_timeout got=none want=done within %0d cycles", budget);
      end
   endtask

   task automatic finish_case(input string name, input int i0, input int f0, input int b0,
                              input int want_in, input int want_flt, input int want_bias);
      int dcyc;
      wait_done(4000, dcyc);
      check({name, "_err"}, longint'(err), 0);
      check({name, "_done_lat"}, dcyc, last_hs_cyc + 1);
      check({name, "_sb_empty"}, exp_q.size(), 0);
      check({name, "_in_reads"}, in_rd_cnt - i0, want_in);
      check({name, "_flt_reads"}, flt_rd_cnt - f0, want_flt);
      check({name, "_bias_reads"}, bias_rd_cnt - b0, want_bias);
      @(posedge clk); #1;
   endtask

   task automatic run_case(input string name, input int want_in, input int want_flt,
                           input int want_bias);
      int i0, f0, b0;
      i0 = in_rd_cnt; f0 = flt_rd_cnt; b0 = bias_rd_cnt;
      pulse_start();
      finish_case(name, i0, f0, b0, want_in, want_flt, want_bias);
   endtask

   task automatic check_quiet(input string name);
      check({name, "_busy"}, longint'(busy), 0);
      check({name, "_done"}, longint'(done), 0);
      check({name, "_err"}, longint'(err), 0);
      check({name, "_out_valid"}, longint'(bus.out_valid), 0);
      check({name, "_rd_en"}, longint'({bus.in_rd_en, bus.flt_rd_en, bus.bias_rd_en}), 0);
      check({name, "_rd_addr"}, longint'(bus.in_rd_addr | bus.flt_rd_addr | bus.bias_rd_addr), 0);
      check({name, "_out_addr"}, longint'(bus.out_addr), 0);
      check({name, "_out_data"}, longint'(bus.out_data), 0);
   endtask

   initial begin
      int t2_exp[9] = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
      int i0, f0, b0, h0, seen;
      logic [ADDR_W-1:0] a_hold;
      logic [ACC_W-1:0]  d_hold;

      bus.out_ready = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         in_mem[i] = '0; flt_mem[i] = '0; bias_mem[i] = '0;
      end
      set_cfg(3, 3, 1, 3, 1, 1, 1, 0);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk); #1 rst = 1'b0;

      // T1: 3x3 all ones, single output 9
      for (int i = 0; i < 9; i++) begin
         in_mem[IN_B + ADDR_W'(i)] = 8'd1; flt_mem[FLT_B + ADDR_W'(i)] = 8'd1;
      end
      bias_mem[BIAS_B] = 32'd0;
      push(0, 9);
      run_case("t1", 9, 9, 1);

      // T2: pad 1, 3x3 outputs in raster order
      set_cfg(3, 3, 1, 3, 3, 3, 1, 1);
      for (int i = 0; i < 9; i++) push(i, t2_exp[i]);
      run_case("t2", 49, 49, 9);

      // T3: four channels, w[c]=c+1, bias[c]=100c
      for (int i = 0; i < 36; i++) in_mem[IN_B + ADDR_W'(i)] = 8'd1;
      for (int k = 0; k < 9; k++)
         for (int c = 0; c < 4; c++) flt_mem[FLT_B + ADDR_W'(k * 4 + c)] = DATA_W'(c + 1);
      for (int c = 0; c < 4; c++) bias_mem[BIAS_B + ADDR_W'(c)] = ACC_W'(100 * c);
      set_cfg(3, 3, 4, 3, 1, 1, 1, 0);
      for (int c = 0; c < 4; c++) push(c, 9 * (c + 1) + 100 * c);
      run_case("t3", 36, 36, 4);

      // T5: same job with the sink stalled for 5 cycles on the first write
      for (int c = 0; c < 4; c++) push(c, 9 * (c + 1) + 100 * c);
      i0 = in_rd_cnt; f0 = flt_rd_cnt; b0 = bias_rd_cnt;
      bus.out_ready = 1'b0;
      pulse_start();
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1;
            break;
         end
      end
      check("t5_valid_seen", seen, 1);
      a_hold = bus.out_addr;
      d_hold = bus.out_data;
      check("t5_first_addr", longint'(a_hold), longint'(OUT_B));
      check("t5_first_data", longint'(d_hold), 9);
      for (int i = 0; i < 5; i++) begin
         check("t5_stall_valid", longint'(bus.out_valid), 1);
         check("t5_stall_addr", longint'(bus.out_addr), longint'(a_hold));
         check("t5_stall_data", longint'(bus.out_data), longint'(d_hold));
         check("t5_stall_no_rd", longint'({bus.in_rd_en, bus.flt_rd_en, bus.bias_rd_en}), 0);
         if (i < 4) @(negedge clk);
      end
      bus.out_ready = 1'b1;
      finish_case("t5", i0, f0, b0, 36, 36, 4);

      // T4: stride 2, x=-128 with offset 128 cancels to bias 7
      for (int i = 0; i < 25; i++) in_mem[IN_B + ADDR_W'(i)] = 8'h80;
      for (int i = 0; i < 9; i++) flt_mem[FLT_B + ADDR_W'(i)] = 8'd5;
      bias_mem[BIAS_B] = 32'd7;
      in_offset = 9'sd128;
      set_cfg(5, 5, 1, 3, 2, 2, 2, 0);
      for (int i = 0; i < 4; i++) push(i, 7);
      run_case("t4", 36, 36, 4);
      in_offset = '0;

      // T6: reset in the middle of the tap phase, then a bad config
      set_cfg(3, 3, 1, 3, 1, 1, 1, 0);
      pulse_start();
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_rd_en) begin
            seen = 1;
            break;
         end
      end
      check("t6_tap_seen", seen, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_quiet("t6_after_rst");
      i0 = in_rd_cnt; f0 = flt_rd_cnt; b0 = bias_rd_cnt; h0 = hs_cnt;
      repeat (20) @(posedge clk);
      check("t6_idle_reads", (in_rd_cnt - i0) + (flt_rd_cnt - f0) + (bias_rd_cnt - b0), 0);
      check("t6_idle_writes", hs_cnt - h0, 0);

      cfg_kw = DIM_W'(0);
      pulse_start();
      @(negedge clk);
      check("t6_cfg_done", longint'(done), 1);
      check("t6_cfg_err", longint'(err), 1);
      @(negedge clk);
      check("t6_cfg_done_pulse", longint'(done), 0);
      check("t6_cfg_busy_after", longint'(busy), 0);
      repeat (5) @(posedge clk);
      check("t6_cfg_reads", (in_rd_cnt - i0) + (flt_rd_cnt - f0) + (bias_rd_cnt - b0), 0);
      check("t6_cfg_writes", hs_cnt - h0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
